i2c_target: RTL and testbench

//   I2C target (slave) front end for the PWM core. Sits on the SCL/SDA bus

---
 rtl/i2c_target_if.sv | 22 ++
 rtl/i2c_target.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// I2C bus bundle: controller-side SCL/SDA drive plus target open-drain pull.
// SDA is the wired-AND of the controller drive and the target pull-down.
interface i2c_target_if;
  logic scl;
  logic sda_drv;
  logic sda_oe;
  logic sda;

  assign sda = sda_drv & ~sda_oe;

  modport master (
    output scl,
    output sda_drv,
    input  sda
  );

  modport slave (
    input  scl,
    input  sda,
    output sda_oe
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target front end decoding [addr+rw][reg_id][data...] frames.
// Define I2C_TARGET_AUTOINC_EN to advance the register pointer per data byte.
module i2c_target #(
  parameter logic [6:0] ADDRESS     = 7'b1110000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s;
  logic rise, fall, start, stop;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       ph_q, ph_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_in;
  logic       last;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign rise  = scl_s & ~scl_prev_q;
  assign fall  = ~scl_s & scl_prev_q;
  assign start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign byte_in = {sh_q[6:0], sda_s};
  assign last    = (cnt_q == 3'd7);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 8'h00;
      ph_q       <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ph_q       <= ph_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ph_d     = ph_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    busy_d   = busy_q;

    // Read data arrives the clk after the strobe; MSB goes straight out.
    if (re_q) begin
      sh_d     = reg_rdata_i;
      sda_oe_d = ~reg_rdata_i[7];
      if (AutoInc) addr_d = addr_q + 8'd1;
    end
    if (we_q && AutoInc) addr_d = addr_q + 8'd1;

    unique case (state_q)
      IDLE: ;
      ADDR, REG, WDATA: begin
        if (rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (last) begin
            ph_d = 1'b0;
            if (state_q == ADDR) begin
              if (byte_in[7:1] == ADDRESS) begin
                state_d = ADDR_ACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end else if (state_q == REG) begin
              addr_d  = byte_in;
              state_d = REG_ACK;
            end else begin
              wdata_d = byte_in;
              we_d    = 1'b1;
              state_d = WDATA_ACK;
            end
          end
        end
      end
      ADDR_ACK, REG_ACK, WDATA_ACK: begin
        // First fall starts the ACK, rise marks it seen, second fall ends it.
        if (fall && !ph_q) sda_oe_d = 1'b1;
        if (rise) ph_d = 1'b1;
        if (fall && ph_q) begin
          sda_oe_d = 1'b0;
          ph_d     = 1'b0;
          cnt_d    = 3'd0;
          if (state_q == ADDR_ACK && rw_q) begin
            state_d = RDATA;
            re_d    = 1'b1;
          end else if (state_q == ADDR_ACK) begin
            state_d = REG;
          end else begin
            state_d = WDATA;
          end
        end
      end
      RDATA: begin
        if (rise) begin
          cnt_d = cnt_q + 3'd1;
          if (last) begin
            state_d = RDATA_ACK;
            ph_d    = 1'b0;
          end
        end
        if (fall) begin
          sh_d     = {sh_q[6:0], 1'b0};
          sda_oe_d = ~sh_q[6];
        end
      end
      RDATA_ACK: begin
        if (fall && !ph_q) sda_oe_d = 1'b0;
        if (rise) begin
          if (sda_s) state_d = WAIT_STOP;
          else       ph_d    = 1'b1;
        end
        if (fall && ph_q) begin
          state_d = RDATA;
          re_d    = 1'b1;
          cnt_d   = 3'd0;
          ph_d    = 1'b0;
        end
      end
      WAIT_STOP: sda_oe_d = 1'b0;
      default:   state_d  = IDLE;
    endcase

    if (start) begin
      state_d  = ADDR;
      cnt_d    = 3'd0;
      ph_d     = 1'b0;
      sda_oe_d = 1'b0;
      we_d     = 1'b0;
      re_d     = 1'b0;
    end
    if (stop) begin
      state_d  = IDLE;
      cnt_d    = 3'd0;
      ph_d     = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      we_d     = 1'b0;
      re_d     = 1'b0;
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C controller plus strobe monitor.
// Expected pointer behaviour follows I2C_TARGET_AUTOINC_EN.
module tb_i2c_target;

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam time Q = 40ns;

  logic       clk;
  logic       rst_n;
  logic [7:0] reg_addr, reg_wdata, rdata;
  logic       we, re, busy;

  int checks = 0;
  int failures = 0;

  i2c_target_if bus ();

  i2c_target dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .scl_i       (bus.scl),
    .sda_i       (bus.sda),
    .sda_oe_o    (bus.sda_oe),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_we_o    (we),
    .reg_re_o    (re),
    .reg_rdata_i (rdata),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5ns clk = ~clk;

  logic [7:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] ra[$];
  int both_cnt = 0;
  bit oe_seen, busy_seen;

  always @(negedge clk) begin
    if (we) begin
      wa.push_back(reg_addr);
      wd.push_back(reg_wdata);
    end
    if (re) ra.push_back(reg_addr);
    if (we && re) both_cnt++;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic clr();
    wa.delete();
    wd.delete();
    ra.delete();
    oe_seen = 1'b0;
    busy_seen = 1'b0;
  endtask

  task automatic i2c_start();
    #Q bus.sda_drv = 1'b1;
    #Q bus.scl = 1'b1;
    #Q bus.sda_drv = 1'b0;
    #Q bus.scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q bus.sda_drv = 1'b0;
    #Q bus.scl = 1'b1;
    #Q bus.sda_drv = 1'b1;
    #Q;
  endtask

  task automatic wbit(input logic b);
    #Q bus.sda_drv = b;
    #Q bus.scl = 1'b1;
    #(2*Q) bus.scl = 1'b0;
  endtask

  task automatic rbit(output logic b);
    bus.sda_drv = 1'b1;
    #(2*Q) bus.scl = 1'b1;
    #Q b = bus.sda;
    #Q bus.scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    ack = ~a;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(nack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.sda_oe !== 1'b0) begin
      failures++; $display("FAIL reset_oe got=%b exp=0", bus.sda_oe);
    end
    checks++;
    if (we !== 1'b0 || re !== 1'b0) begin
      failures++; $display("FAIL reset_strobes got=%b%b exp=00", we, re);
    end
    checks++;
    if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_regs got=%h/%h exp=00/00", reg_addr, reg_wdata);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    logic bz;
    clr();
    i2c_start();
    wbyte(8'hE0, a0);
    bz = busy;
    wbyte(8'hDE, a1);
    wbyte(8'h4D, a2);
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      failures++; $display("FAIL wr_acks got=%b exp=111", {a0, a1, a2});
    end
    checks++;
    if (bz !== 1'b1) begin
      failures++; $display("FAIL wr_busy_on got=%b exp=1", bz);
    end
    checks++;
    if (wa.size() !== 1) begin
      failures++; $display("FAIL wr_we_count got=%0d exp=1", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 8'hDE || wd[0] !== 8'h4D) begin
        failures++;
        $display("FAIL wr_data got=%h=%h exp=DE=4D", wa[0], wd[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL wr_busy_off got=%b exp=0", busy);
    end
    checks++;
    if (reg_addr !== (AUTO ? 8'hDF : 8'hDE)) begin
      failures++;
      $display("FAIL wr_ptr got=%h exp=%h", reg_addr, AUTO ? 8'hDF : 8'hDE);
    end
  endtask

  task automatic test_nack();
    logic a0, a1, a2;
    clr();
    i2c_start();
    wbyte(8'hE2, a0);
    wbyte(8'hDE, a1);
    wbyte(8'h4D, a2);
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      failures++; $display("FAIL na_acks got=%b exp=000", {a0, a1, a2});
    end
    checks++;
    if (oe_seen !== 1'b0) begin
      failures++; $display("FAIL na_oe got=%b exp=0", oe_seen);
    end
    checks++;
    if (wa.size() !== 0) begin
      failures++; $display("FAIL na_we got=%0d exp=0", wa.size());
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      failures++; $display("FAIL na_busy got=%b exp=0", busy_seen);
    end
  endtask

  task automatic test_autoinc();
    logic a;
    logic [7:0] exp_a1;
    clr();
    exp_a1 = AUTO ? 8'h00 : 8'hFF;
    i2c_start();
    wbyte(8'hE0, a);
    wbyte(8'hFF, a);
    wbyte(8'h11, a);
    wbyte(8'h22, a);
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() !== 2) begin
      failures++; $display("FAIL ai_count got=%0d exp=2", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 8'hFF || wd[0] !== 8'h11) begin
        failures++;
        $display("FAIL ai_first got=%h=%h exp=FF=11", wa[0], wd[0]);
      end
      checks++;
      if (wa[1] !== exp_a1 || wd[1] !== 8'h22) begin
        failures++;
        $display("FAIL ai_second got=%h=%h exp=%h=22", wa[1], wd[1], exp_a1);
      end
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d;
    logic bz;
    clr();
    i2c_start();
    wbyte(8'hE0, a0);
    wbyte(8'h06, a1);
    i2c_start();
    wbyte(8'hE1, a2);
    rbyte(1'b1, d);
    repeat (4) @(negedge clk);
    bz = busy;
    checks++;
    if (bus.sda_oe !== 1'b0) begin
      failures++; $display("FAIL rd_wait_oe got=%b exp=0", bus.sda_oe);
    end
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      failures++; $display("FAIL rd_acks got=%b exp=111", {a0, a1, a2});
    end
    checks++;
    if (d !== 8'hA5) begin
      failures++; $display("FAIL rd_data got=%h exp=A5", d);
    end
    checks++;
    if (ra.size() !== 1) begin
      failures++; $display("FAIL rd_re_count got=%0d exp=1", ra.size());
    end else begin
      checks++;
      if (ra[0] !== 8'h06) begin
        failures++; $display("FAIL rd_re_addr got=%h exp=06", ra[0]);
      end
    end
    checks++;
    if (bz !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rd_busy got=%b%b exp=10", bz, busy);
    end
    checks++;
    if (wa.size() !== 0) begin
      failures++; $display("FAIL rd_no_we got=%0d exp=0", wa.size());
    end
    checks++;
    if (reg_addr !== (AUTO ? 8'h07 : 8'h06)) begin
      failures++;
      $display("FAIL rd_ptr got=%h exp=%h", reg_addr, AUTO ? 8'h07 : 8'h06);
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic oe_ack;
    clr();
    // Reset while the target is pulling the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(1'(8'hE0 >> i));
    bus.sda_drv = 1'b1;
    #Q oe_ack = bus.sda_oe;
    rst_n = 1'b0;
    #1ns;
    checks++;
    if (oe_ack !== 1'b1 || bus.sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL rm_ack_oe got=%b%b exp=10", oe_ack, bus.sda_oe);
    end
    #(Q - 1ns) rst_n = 1'b1;
    bus.scl = 1'b1;
    #(2*Q) bus.scl = 1'b0;
    i2c_stop();
    repeat (4) @(negedge clk);
    // Reset during the 4th data bit.
    i2c_start();
    wbyte(8'hE0, a);
    wbyte(8'h10, a);
    for (int i = 0; i < 3; i++) wbit(1'b1);
    #Q bus.sda_drv = 1'b0;
    #Q bus.scl = 1'b1;
    #Q rst_n = 1'b0;
    #1ns;
    checks++;
    if (bus.sda_oe !== 1'b0) begin
      failures++; $display("FAIL rm_oe got=%b exp=0", bus.sda_oe);
    end
    #(Q - 1ns) bus.scl = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wbit(1'b1);
    rbit(a);
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() !== 0) begin
      failures++; $display("FAIL rm_no_we got=%0d exp=0", wa.size());
    end
    clr();
    i2c_start();
    wbyte(8'hE0, a);
    wbyte(8'h33, a);
    wbyte(8'h5A, a);
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() !== 1) begin
      failures++; $display("FAIL rm_next_count got=%0d exp=1", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 8'h33 || wd[0] !== 8'h5A) begin
        failures++;
        $display("FAIL rm_next_data got=%h=%h exp=33=5A", wa[0], wd[0]);
      end
    end
  endtask

  task automatic test_partial();
    logic a;
    clr();
    i2c_start();
    wbyte(8'hE0, a);
    wbyte(8'h44, a);
    for (int i = 0; i < 5; i++) wbit(1'(i & 1));
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() !== 0) begin
      failures++; $display("FAIL pt_no_we got=%0d exp=0", wa.size());
    end
    checks++;
    if (busy !== 1'b0 || bus.sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL pt_idle got=%b%b exp=00", busy, bus.sda_oe);
    end
    checks++;
    if (reg_wdata !== 8'h5A) begin
      failures++; $display("FAIL pt_wdata got=%h exp=5A", reg_wdata);
    end
    clr();
    i2c_start();
    wbyte(8'hE0, a);
    wbyte(8'h45, a);
    wbyte(8'h99, a);
    i2c_stop();
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() !== 1 || wd[0] !== 8'h99) begin
      failures++; $display("FAIL pt_next got=%0d exp=1", wa.size());
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt !== 0) begin
      failures++; $display("FAIL we_re_overlap got=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    bus.scl = 1'b1;
    bus.sda_drv = 1'b1;
    rdata = 8'hA5;
    rst_n = 1'b0;
    test_reset();
    test_write();
    test_nack();
    test_autoinc();
    test_read();
    test_reset_mid();
    test_partial();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
